unidade_de_busca: RTL and testbench

Instruction fetch and program-counter stage of the 8-bit nRisc core, directly upstream of `unidade_de_controle`. Holds the PC, addresses the instruction ROM, latches the fetched word into the instruction register and presents `Opcode` to the control unit. It sequences each instruction through FETCH, DECODE and EXEC, and computes the next PC from the control unit's registered `Jump`, `BEQ` and `PCWrite` outputs and the ULA `Zero` flag. A HALT instruction stops the core until `Reset`.

---
 rtl/unidade_de_busca_pkg.sv | 20 ++
 rtl/unidade_de_busca_if.sv | 22 ++
 rtl/unidade_de_busca_proximo_pc.sv | 17 +
 rtl/unidade_de_busca.sv | 52 +++++
 tb/tb_unidade_de_busca.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/unidade_de_busca_pkg.sv
// unidade_de_busca_pkg: nRisc opcodes, fetch-stage state encodings and instruction field positions
package unidade_de_busca_pkg;
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_LA    = 3'b001;
   localparam logic [2:0] OP_STORE = 3'b010;
   localparam logic [2:0] OP_ADD   = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_J     = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;
   localparam int OP_MSB   = 7;
   localparam int OP_LSB   = 5;
   localparam int JOFF_MSB = 4;
   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10,
      HALT   = 2'b11
   } fase_t;
endpackage

// File: rtl/unidade_de_busca_if.sv
// unidade_de_busca_if: ROM, control-unit and status signals of the fetch stage
interface unidade_de_busca_if #(parameter int PC_W = 8);
   logic [7:0]      InstrData;
   logic            Jump;
   logic            BEQ;
   logic            PCWrite;
   logic            Zero;
   logic [PC_W-1:0] InstrAddr;
   logic [7:0]      Instr;
   logic [2:0]      Opcode;
   logic            ExecEn;
   logic [1:0]      Fase;
   logic            Halted;
   modport master (
      output InstrData, Jump, BEQ, PCWrite, Zero,
      input  InstrAddr, Instr, Opcode, ExecEn, Fase, Halted
   );
   modport slave (
      input  InstrData, Jump, BEQ, PCWrite, Zero,
      output InstrAddr, Instr, Opcode, ExecEn, Fase, Halted
   );
endinterface

// File: rtl/unidade_de_busca_proximo_pc.sv
// proximo_pc: next-PC select; relative jump beats taken branch beats sequential step
module proximo_pc
   import unidade_de_busca_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [PC_W-1:0] pc,
   input  logic [JOFF_MSB:0] offset,
   input  logic            jump,
   input  logic            beq,
   input  logic            zero,
   output logic [PC_W-1:0] pc_next
);
   logic [PC_W-1:0] sext;
   assign sext = {{(PC_W-JOFF_MSB-1){offset[JOFF_MSB]}}, offset};
   assign pc_next = jump ? pc + sext : pc + ((beq & zero) ? PC_W'(2) : PC_W'(1));
endmodule

// File: rtl/unidade_de_busca.sv
// unidade_de_busca: nRisc fetch stage; PC and instruction register sequenced FETCH -> DECODE -> EXEC,
// with HALT absorbing until reset
module unidade_de_busca
   import unidade_de_busca_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic Clock,
   input logic Reset,
   unidade_de_busca_if.slave bus
);
   fase_t           fase;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic [7:0]      instr;
   proximo_pc #(.PC_W(PC_W)) u_proximo_pc (
      .pc(pc),
      .offset(instr[JOFF_MSB:0]),
      .jump(bus.Jump),
      .beq(bus.BEQ),
      .zero(bus.Zero),
      .pc_next(pc_next)
   );
   // control inputs are only looked at in EXEC, so their value elsewhere never matters
   always_ff @(posedge Clock) begin
      if (Reset) begin
         fase  <= FETCH;
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         case (fase)
            FETCH: begin
               instr <= bus.InstrData;
               fase  <= DECODE;
            end
            DECODE: fase <= EXEC;
            EXEC: begin
               if (bus.PCWrite) pc <= pc_next;
               fase <= bus.PCWrite ? FETCH : HALT;
            end
            default: fase <= HALT;
         endcase
      end
   end
   assign bus.InstrAddr = pc;
   assign bus.Instr     = instr;
   assign bus.Opcode    = instr[OP_MSB:OP_LSB];
   assign bus.Fase      = fase;
   assign bus.ExecEn    = (fase == EXEC);
   assign bus.Halted    = (fase == HALT);
endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca: directed scenarios plus random instruction stream against a PC reference model
module tb_unidade_de_busca;
   logic Clock = 0;
   logic Reset = 1;
   logic [7:0] rom [256];
   logic [7:0] mpc = 8'h00;
   int passed = 0;
   int total = 0;
   logic [7:0] o_afetch, o_adec, o_instr, o_aexec;
   logic [2:0] o_op;
   logic [1:0] o_ffetch, o_fexec;
   logic o_exfetch, o_exdec, o_exexec;

   unidade_de_busca_if #(.PC_W(8)) bus ();
   unidade_de_busca #(.PC_W(8), .RESET_PC(8'h00)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   always #5 Clock = ~Clock;
   assign bus.InstrData = rom[bus.InstrAddr];

   function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [7:0] w,
                                             input logic j, input logic b, input logic z, input logic pw);
      int off;
      off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
      if (!pw) return pc;
      if (j) return 8'((int'(pc) + off + 256) % 256);
      if (b && z) return 8'((int'(pc) + 2) % 256);
      return 8'((int'(pc) + 1) % 256);
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic junk();
      bus.Jump = 1'($urandom);
      bus.BEQ = 1'($urandom);
      bus.Zero = 1'($urandom);
      bus.PCWrite = 1'($urandom);
   endtask

   task automatic do_reset();
      Reset = 1;
      junk();
      step();
      Reset = 0;
      mpc = 8'h00;
   endtask

   // runs one full instruction starting in FETCH; observations land in o_* and the model advances
   task automatic run_instr(input logic [7:0] word, input logic j, input logic b, input logic z,
                            input logic pw, input bit rst_exec);
      rom[mpc] = word;
      #0;
      o_afetch = bus.InstrAddr; o_ffetch = bus.Fase; o_exfetch = bus.ExecEn;
      junk();
      step();
      o_adec = bus.InstrAddr; o_exdec = bus.ExecEn;
      junk();
      step();
      bus.Jump = j; bus.BEQ = b; bus.Zero = z; bus.PCWrite = pw;
      Reset = rst_exec;
      #0;
      o_fexec = bus.Fase; o_exexec = bus.ExecEn; o_instr = bus.Instr; o_op = bus.Opcode; o_aexec = bus.InstrAddr;
      step();
      Reset = 0;
      mpc = rst_exec ? 8'h00 : model_next(mpc, word, j, b, z, pw);
      junk();
   endtask

   task automatic goto_pc(input logic [7:0] t);
      logic [7:0] d;
      for (int k = 0; k < 64 && mpc != t; k++) begin
         d = t - mpc;
         if (d >= 8'd15) run_instr({3'b110, 5'd15}, 1, 1, 0, 1, 0);
         else run_instr(8'h60, 0, 0, 0, 1, 0);
      end
   endtask

   task automatic test_reset();
      Reset = 1;
      junk();
      step();
      step();
      total++; if (bus.InstrAddr !== 8'h00) $display("FAIL reset_addr got %h want 00", bus.InstrAddr); else passed++;
      total++; if (bus.Instr !== 8'h00) $display("FAIL reset_instr got %h want 00", bus.Instr); else passed++;
      total++; if (bus.Opcode !== 3'b000) $display("FAIL reset_opcode got %b want 000", bus.Opcode); else passed++;
      total++; if (bus.Fase !== 2'b00) $display("FAIL reset_fase got %b want 00", bus.Fase); else passed++;
      total++; if (bus.ExecEn !== 1'b0) $display("FAIL reset_execen got %b want 0", bus.ExecEn); else passed++;
      total++; if (bus.Halted !== 1'b0) $display("FAIL reset_halted got %b want 0", bus.Halted); else passed++;
      Reset = 0;
      mpc = 8'h00;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         run_instr(8'h60 | 8'(i), 0, 0, 0, 1, 0);
         total++; if (o_afetch !== 8'(i)) $display("FAIL seq_addr%0d got %h want %h", i, o_afetch, 8'(i)); else passed++;
         total++; if ({o_exfetch, o_exdec, o_exexec} !== 3'b001) $display("FAIL seq_execen%0d got %b want 001", i, {o_exfetch, o_exdec, o_exexec}); else passed++;
         total++; if (o_fexec !== 2'b10) $display("FAIL seq_fase%0d got %b want 10", i, o_fexec); else passed++;
      end
      total++; if (bus.InstrAddr !== 8'h04) $display("FAIL seq_end got %h want 04", bus.InstrAddr); else passed++;
   endtask

   task automatic test_halt();
      run_instr(8'hE0, 0, 0, 0, 0, 0);
      total++; if ({bus.Fase, bus.Halted} !== 3'b111) $display("FAIL halt_enter got %b want 111", {bus.Fase, bus.Halted}); else passed++;
      for (int i = 0; i < 20; i++) begin
         rom[8'h04] = 8'($urandom);
         junk();
         step();
         total++;
         if (bus.InstrAddr !== 8'h04 || bus.Fase !== 2'b11 || bus.Halted !== 1'b1 || bus.Instr !== 8'hE0 || bus.ExecEn !== 1'b0)
            $display("FAIL halt_hold%0d got addr=%h fase=%b halted=%b instr=%h want 04 11 1 e0", i, bus.InstrAddr, bus.Fase, bus.Halted, bus.Instr);
         else passed++;
      end
      Reset = 1;
      step();
      Reset = 0;
      mpc = 8'h00;
      total++;
      if (bus.InstrAddr !== 8'h00 || bus.Instr !== 8'h00 || bus.Fase !== 2'b00 || bus.Halted !== 1'b0)
         $display("FAIL halt_reset got addr=%h instr=%h fase=%b halted=%b want 00 00 00 0", bus.InstrAddr, bus.Instr, bus.Fase, bus.Halted);
      else passed++;
   endtask

   task automatic test_branch();
      goto_pc(8'h05);
      run_instr(8'hA0, 0, 1, 1, 1, 0);
      total++; if (bus.InstrAddr !== 8'h07) $display("FAIL beq_taken got %h want 07", bus.InstrAddr); else passed++;
      do_reset();
      goto_pc(8'h05);
      run_instr(8'hA0, 0, 1, 0, 1, 0);
      total++; if (bus.InstrAddr !== 8'h06) $display("FAIL beq_not_taken got %h want 06", bus.InstrAddr); else passed++;
   endtask

   task automatic test_jump_priority();
      goto_pc(8'h10);
      run_instr({3'b110, 5'b11100}, 1, 1, 1, 1, 0);
      total++; if (bus.InstrAddr !== 8'h0C) $display("FAIL jump_back got %h want 0c", bus.InstrAddr); else passed++;
      goto_pc(8'h10);
      run_instr({3'b110, 5'b01111}, 1, 1, 1, 1, 0);
      total++; if (bus.InstrAddr !== 8'h1F) $display("FAIL jump_fwd got %h want 1f", bus.InstrAddr); else passed++;
   endtask

   task automatic test_wrap();
      goto_pc(8'hFF);
      run_instr(8'h60, 0, 0, 0, 1, 0);
      total++; if (bus.InstrAddr !== 8'h00) $display("FAIL wrap_inc got %h want 00", bus.InstrAddr); else passed++;
      goto_pc(8'h02);
      run_instr({3'b110, 5'b10000}, 1, 1, 0, 1, 0);
      total++; if (bus.InstrAddr !== 8'hF2) $display("FAIL wrap_jump got %h want f2", bus.InstrAddr); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      goto_pc(8'h10);
      run_instr({3'b110, 5'b11100}, 1, 1, 1, 1, 1);
      total++;
      if (bus.InstrAddr !== 8'h00 || bus.Instr !== 8'h00 || bus.Fase !== 2'b00 || bus.Halted !== 1'b0)
         $display("FAIL reset_exec got addr=%h instr=%h fase=%b halted=%b want 00 00 00 0", bus.InstrAddr, bus.Instr, bus.Fase, bus.Halted);
      else passed++;
   endtask

   task automatic test_random();
      logic [7:0] w;
      logic j, b, z;
      for (int i = 0; i < 80; i++) begin
         w = 8'($urandom);
         j = 1'($urandom);
         b = 1'($urandom);
         z = 1'($urandom);
         run_instr(w, j, b, z, 1, 0);
         total++;
         if (o_adec !== o_afetch || o_aexec !== o_afetch || o_instr !== w || o_op !== w[7:5] || o_exexec !== 1'b1)
            $display("FAIL rand_exec%0d got addr=%h/%h instr=%h op=%b en=%b want addr=%h instr=%h", i, o_adec, o_aexec, o_instr, o_op, o_exexec, o_afetch, w);
         else passed++;
         total++; if (bus.InstrAddr !== mpc) $display("FAIL rand_next%0d got %h want %h", i, bus.InstrAddr, mpc); else passed++;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'h60;
      junk();
      test_reset();
      test_sequential();
      test_halt();
      test_branch();
      test_jump_priority();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
